// File: rtl/arb_burst_channel.sv
// Burst channel behind the 4-agent request/grant arbiter: moves one granted agent's burst
// onto a single registered output stream, with done pulses and abort/timeout/grant errors.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// S_IDLE    | no burst; waiting for exactly one grant
// S_XFER    | moving beats from the latched source agent to the output register
// S_RELEASE | burst over; waiting for all grants low and the output drained
// S_ERR     | several grants seen at once; err is high for this one cycle
module arb_burst_channel #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16,
    parameter int TIMEOUT   = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         gnt_0,
    input  logic                         gnt_1,
    input  logic                         gnt_2,
    input  logic                         gnt_3,
    input  logic                         vld_0,
    input  logic                         vld_1,
    input  logic                         vld_2,
    input  logic                         vld_3,
    input  logic [DATA_W-1:0]            dat_0,
    input  logic [DATA_W-1:0]            dat_1,
    input  logic [DATA_W-1:0]            dat_2,
    input  logic [DATA_W-1:0]            dat_3,
    input  logic                         last_0,
    input  logic                         last_1,
    input  logic                         last_2,
    input  logic                         last_3,
    output logic                         rdy_0,
    output logic                         rdy_1,
    output logic                         rdy_2,
    output logic                         rdy_3,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [1:0]                   out_src,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic                         done_0,
    output logic                         done_1,
    output logic                         done_2,
    output logic                         done_3,
    output logic                         err,
    output logic [$clog2(MAX_BEATS):0]   beat_cnt
);

    localparam int CNT_W   = $clog2(MAX_BEATS) + 1;
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_RELEASE,
        S_ERR
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [1:0]           src;
    logic [STALL_W-1:0]   stall_cnt;
    logic [3:0]           done_q;
    logic [3:0]           done_nxt;
    logic                 err_nxt;
    logic                 start;

    logic [3:0]           gnt_vec;
    logic [3:0]           vld_vec;
    logic [3:0]           lst_vec;
    logic [DATA_W-1:0]    dat_arr [4];
    logic [1:0]           gnt_idx;
    logic                 gnt_one;
    logic [3:0]           rdy_vec;
    logic                 src_ready;
    logic                 take_beat;
    logic                 end_beat;
    logic                 stall_out;

    assign gnt_vec    = {gnt_3, gnt_2, gnt_1, gnt_0};
    assign vld_vec    = {vld_3, vld_2, vld_1, vld_0};
    assign lst_vec    = {last_3, last_2, last_1, last_0};
    assign dat_arr[0] = dat_0;
    assign dat_arr[1] = dat_1;
    assign dat_arr[2] = dat_2;
    assign dat_arr[3] = dat_3;

    // Exactly one grant bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign gnt_one = (gnt_vec != 4'b0) && ((gnt_vec & (gnt_vec - 4'd1)) == 4'b0);

    always_comb begin
        gnt_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (gnt_vec[i]) gnt_idx = 2'(i);
        end
    end

    // A dropped grant masks ready, so grant loss always wins over an offered beat.
    always_comb begin
        src_ready = 1'b0;
        rdy_vec   = 4'b0;
        if (state == S_XFER && gnt_vec[src]) begin
            src_ready = !out_valid || out_ready;
        end
        rdy_vec[src] = src_ready;
    end

    assign take_beat = src_ready && vld_vec[src];
    assign end_beat  = take_beat && (lst_vec[src] || beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign stall_out = (stall_cnt == STALL_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        done_nxt  = 4'b0;
        err_nxt   = 1'b0;
        start     = 1'b0;
        case (state)
            S_IDLE: begin
                if (gnt_one) begin
                    start     = 1'b1;
                    state_nxt = S_XFER;
                end else if (gnt_vec != 4'b0) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_ERR;
                end
            end
            S_XFER: begin
                if (!gnt_vec[src]) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_RELEASE;
                end else if (end_beat) begin
                    done_nxt[src] = 1'b1;
                    state_nxt     = S_RELEASE;
                end else if (!take_beat && stall_out) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (gnt_vec == 4'b0 && !out_valid) state_nxt = S_IDLE;
            end
            S_ERR: begin
                state_nxt = S_RELEASE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            src       <= 2'd0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            done_q    <= 4'b0;
            err       <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            err    <= err_nxt;
            if (start) begin
                src       <= gnt_idx;
                beat_cnt  <= '0;
                stall_cnt <= '0;
            end else if (take_beat) begin
                beat_cnt  <= beat_cnt + 1'b1;
                stall_cnt <= '0;
            end else if (state == S_XFER) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // Output register: a held beat stays put until out_ready; a beat still held at
    // abort or timeout drains normally with whatever out_last it was loaded with.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
            out_last  <= 1'b0;
        end else if (take_beat) begin
            out_valid <= 1'b1;
            out_data  <= dat_arr[src];
            out_src   <= src;
            out_last  <= end_beat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign rdy_0  = rdy_vec[0];
    assign rdy_1  = rdy_vec[1];
    assign rdy_2  = rdy_vec[2];
    assign rdy_3  = rdy_vec[3];
    assign done_0 = done_q[0];
    assign done_1 = done_q[1];
    assign done_2 = done_q[2];
    assign done_3 = done_q[3];

endmodule

// File: doc/arb_burst_channel.md
Name: arb_burst_channel

Overview:
- Downstream consumer of the 4-agent request/grant arbiter; takes its registered one-hot grants gnt_0..gnt_3 and moves one data burst from the granted agent onto a single shared output stream.
- Signals burst completion per agent so the agent drops its request, returning the arbiter to idle.
- Provides abort, timeout and illegal-grant detection.

Parameters:
- DATA_W, 8, width of agent and output data.
- MAX_BEATS, 16, maximum beats per burst; the burst is force-terminated at this count. Legal range 2..256.
- TIMEOUT, 32, consecutive stalled XFER cycles (no accepted beat) before abort. Must be at least 2.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- gnt_0..gnt_3  in  1 each  grants from arbiter
- vld_0..vld_3  in  1 each  agent beat valid
- dat_0..dat_3  in  DATA_W each  agent beat data
- last_0..last_3  in  1 each  agent marks final beat
- rdy_0..rdy_3  out  1 each  beat accepted from agent when vld_n & rdy_n
- out_valid  out  1  output register holds a beat
- out_data  out  DATA_W  output beat data
- out_src  out  2  agent index of the output beat
- out_last  out  1  final beat of the burst, natural or forced
- out_ready  in  1  downstream accepts when out_valid & out_ready
- done_0..done_3  out  1 each  one-cycle pulse at burst end
- err  out  1  one-cycle pulse on abort, timeout or illegal grant
- beat_cnt  out  $clog2(MAX_BEATS)+1  beats accepted in the current burst

Behaviour:
- Reset (synchronous; also honoured mid-burst):
  - State goes to IDLE; all outputs go to 0, including out_valid, beat_cnt and the stall counter.
  - A beat held in the output register is discarded.
- States: IDLE, XFER, RELEASE, ERR.
- IDLE:
  - Exactly one gnt_n high: latch src=n, clear beat_cnt and the stall counter, go to XFER next cycle.
  - Two or more gnt high: go to ERR.
  - All grants low: stay in IDLE.
  - rdy_* = 0 in IDLE.
- XFER:
  - Only rdy_src may be high: rdy_src = !out_valid | out_ready. All other rdy_* = 0.
  - Accepted beat loads out_data=dat_src, out_src=src and out_valid=1 on the next edge; beat_cnt increments.
  - The output register holds its value while out_valid & !out_ready.
  - out_valid clears when the held beat is accepted and no new beat is loaded in the same cycle.
  - Throughput is one beat per cycle when out_ready is held high; latency is 1 cycle from agent to output.
- Burst end (checked on an accepted beat in XFER):
  - End when last_src=1, or when beat_cnt == MAX_BEATS-1 before the increment (forced end).
  - Either case sets out_last=1 on that beat.
  - Pulse done_src for exactly one cycle, the cycle after acceptance; go to RELEASE.
- Stall counter:
  - Increments each XFER cycle with no accepted beat; resets to 0 on every accepted beat.
  - Reaching TIMEOUT: pulse err, no done pulse, go to RELEASE. The beat already in the output register still drains with out_last=0.
- Grant loss: gnt_src low in XFER before burst end aborts the burst. Pulse err, no done pulse, go to RELEASE.
- Grant change: any other gnt bit rising in XFER is ignored; src stays fixed for the burst.
- RELEASE:
  - rdy_* = 0.
  - Wait until all gnt_* are low and out_valid=0, then go to IDLE.
  - Covers the arbiter's registered-grant lag of 2+ cycles after req drops.
- ERR: pulse err for one cycle, then go to RELEASE.
- Simultaneous events in one XFER cycle, in priority order:
  1. Grant loss wins over an offered beat: the beat is not accepted, and rdy_src must be 0 that cycle when gnt_src=0.
  2. Burst end wins over timeout.
- err and done never pulse in the same cycle.

Test Plan:
- Basic burst:
  - Stimulus: reset 2 cycles; gnt_1=1; agent 1 sends 4 beats 0x10..0x13, last on 0x13; out_ready=1.
  - Response: out_data 0x10..0x13 in consecutive cycles with out_src=1; out_last on 0x13; done_1 pulses once; beat_cnt=4.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1 during a 3-beat burst from agent 2.
  - Response: no beat lost or duplicated; rdy_2=0 while out_valid & !out_ready; order 0xA0,0xA1,0xA2.
- Forced end:
  - Stimulus: agent 0 streams with last_0=0, MAX_BEATS=16.
  - Response: the 16th beat has out_last=1; done_0 pulses; rdy_0 goes 0 in RELEASE.
- Timeout:
  - Stimulus: gnt_3=1, vld_3 held 0 for 32 cycles.
  - Response: err pulses after 32 stalled cycles; no done_3; returns to IDLE only after gnt_3 falls.
- Illegal grant and abort:
  - Stimulus A: gnt_0=gnt_2=1 in IDLE. Response: err pulse, no rdy_* asserted.
  - Stimulus B: gnt_1 dropped after 2 of 5 beats. Response: err pulse, no out_last.
- Mid-burst reset:
  - Stimulus: assert reset during the 3rd beat with out_valid=1.
  - Response: next cycle out_valid=0, beat_cnt=0, all rdy/done/err=0, state IDLE.
